// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_e;

    localparam int unsigned MAX_NUM_RD = 8;

    function automatic int unsigned lanes(input int unsigned data_width,
                                          input int unsigned byte_w);
        return data_width / byte_w;
    endfunction

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Clear-sweep sequencer: walks every entry once after reset or on a clr request.
//
// state | meaning
// CLEAR | sweep in progress, entry[cnt] zeroed each edge, busy=1
// IDLE  | array available for user writes and reads, clr accepted
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  clr_next_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                // Counter wraps back to 0 on the final entry, ready for the next sweep.
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o     = (state_q == CLEAR);
        clr_we_o   = (state_q == CLEAR);
        clr_addr_o = cnt_q;
        clr_next_o = (state_d == CLEAR);
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-lane writes, optional registered
// write-first reads, and a hardware zeroing sweep after reset or on request.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned REG_RD     = 1,
    parameter int unsigned BYTE_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          w_addr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   w_be,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
    output logic                           busy
);

    localparam int unsigned LANES = lanes(DATA_WIDTH, BYTE_W);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_byte_w
        $error("reg_file_mp: DATA_WIDTH must be a multiple of BYTE_W");
    end
    if ((NUM_RD < 1) || (NUM_RD > MAX_NUM_RD)) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be in 1..8");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_next;

    reg_file_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (clr),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_next_o (clr_next)
    );

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_word;

    // A concurrent clr request takes priority over the user write.
    assign wr_accept = wr_en && !busy && !clr;

    always_comb begin
        wr_word = mem_q[w_addr];
        for (int i = 0; i < LANES; i++) begin
            if (w_be[i]) begin
                wr_word[i*BYTE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        arr_we   = rst_n && (clr_we || wr_accept);
        arr_addr = clr_we ? clr_addr : w_addr;
        arr_word = clr_we ? '0 : wr_word;
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_word;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr;
        assign rd_addr = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        if (REG_RD != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q, rd_d;

            // Bypass covers the sweep write too, so the last cleared entry never reads stale.
            always_comb begin
                rd_d = mem_q[rd_addr];
                if (clr_next) begin
                    rd_d = '0;
                end else if (arr_we && (arr_addr == rd_addr)) begin
                    rd_d = arr_word;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
        end else begin : g_comb
            assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : mem_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: registered-read and combinational-read instances share one stimulus stream.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 4;

    localparam int K_BUSY_R = 0;
    localparam int K_BUSY_C = 1;
    localparam int K_REG_P0 = 2;
    localparam int K_REG_P1 = 3;
    localparam int K_CMB_P0 = 4;
    localparam int K_CMB_P1 = 5;

    typedef struct {
        int          stamp;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr;
    logic            wr_en;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [3:0]      w_be;
    logic [2*AW-1:0] r_addr;
    logic [2*DW-1:0] rd_r, rd_c;
    logic            busy_r, busy_c;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .REG_RD(1), .BYTE_W(8)) u_reg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .w_be(w_be), .r_addr(r_addr), .r_data(rd_r), .busy(busy_r)
    );

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .REG_RD(0), .BYTE_W(8)) u_cmb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .w_be(w_be), .r_addr(r_addr), .r_data(rd_c), .busy(busy_c)
    );

    function automatic logic [31:0] get_act(input int kind);
        case (kind)
            K_BUSY_R: return {31'b0, busy_r};
            K_BUSY_C: return {31'b0, busy_c};
            K_REG_P0: return rd_r[31:0];
            K_REG_P1: return rd_r[63:32];
            K_CMB_P0: return rd_c[31:0];
            default:  return rd_c[63:32];
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin : monitor
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].stamp <= cyc) begin
                act = get_act(sb[i].kind);
                n_vec++;
                if (sb[i].stamp < cyc || act !== sb[i].exp) begin
                    n_miss++;
                    $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int kind, input int off, input logic [31:0] val, input string nm);
        exp_t e;
        e.stamp = cyc + off;
        e.kind  = kind;
        e.exp   = val;
        e.name  = nm;
        sb.push_back(e);
    endtask

    task automatic exp_busy(input int off, input logic b, input string nm);
        exp_at(K_BUSY_R, off, {31'b0, b}, {nm, "_busy_reg"});
        exp_at(K_BUSY_C, off, {31'b0, b}, {nm, "_busy_cmb"});
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        r_addr = {a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en  = 1'b1;
        w_addr = a;
        w_data = d;
        w_be   = be;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0;
        w_addr = '0; w_data = '0; w_be = '0; r_addr = '0;

        // Reset held for 3 edges, then a 16-edge sweep.
        tick();
        exp_busy(0, 1'b1, "rst");
        exp_at(K_REG_P0, 0, 32'h0, "rst_rdata_p0");
        exp_at(K_REG_P1, 0, 32'h0, "rst_rdata_p1");
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) exp_busy(j, 1'b1, "rst_sweep");
        exp_busy(16, 1'b0, "rst_done");
        repeat (16) tick();

        // Every entry reads zero on both ports.
        for (int a = 0; a < 16; a++) begin
            set_rd(AW'(a), AW'(15 - a));
            exp_at(K_CMB_P0, 0, 32'h0, "zero_cmb_p0");
            exp_at(K_CMB_P1, 0, 32'h0, "zero_cmb_p1");
            exp_at(K_REG_P0, 1, 32'h0, "zero_reg_p0");
            exp_at(K_REG_P1, 1, 32'h0, "zero_reg_p1");
            tick();
        end

        // Byte-lane merge.
        set_rd(4'd5, 4'd6);
        wr(4'd5, 32'hAABBCCDD, 4'b1111);
        exp_at(K_CMB_P0, 0, 32'h0, "be1_cmb_old");
        exp_at(K_REG_P0, 1, 32'hAABBCCDD, "be1_reg_bypass");
        exp_at(K_REG_P1, 1, 32'h0, "be1_reg_p1");
        tick();
        wr(4'd5, 32'h11223344, 4'b0101);
        exp_at(K_CMB_P0, 0, 32'hAABBCCDD, "be2_cmb_old");
        exp_at(K_REG_P0, 1, 32'hAA22CC44, "be2_reg_bypass");
        tick();
        wr_en = 1'b0;
        exp_at(K_CMB_P0, 0, 32'hAA22CC44, "be2_cmb_after");
        exp_at(K_REG_P0, 1, 32'hAA22CC44, "be2_reg_after");
        tick();

        // Write-first bypass vs combinational pre-write value.
        wr(4'd4, 32'h00000077, 4'b0001);
        tick();
        set_rd(4'd3, 4'd4);
        wr(4'd3, 32'h0000005A, 4'b1111);
        exp_at(K_CMB_P0, 0, 32'h0, "byp_cmb_p0_old");
        exp_at(K_CMB_P1, 0, 32'h77, "byp_cmb_p1");
        exp_at(K_REG_P0, 1, 32'h5A, "byp_reg_p0");
        exp_at(K_REG_P1, 1, 32'h77, "byp_reg_p1_old");
        tick();
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        exp_at(K_CMB_P0, 0, 32'h5A, "byp_cmb_p0_new");
        exp_at(K_REG_P0, 1, 32'h5A, "be0_reg_noop");
        tick();
        wr_en = 1'b0;
        exp_at(K_CMB_P0, 0, 32'h5A, "be0_cmb_noop");
        tick();

        // clr with a concurrent write, then writes during the sweep.
        wr(4'd2, 32'h12345678, 4'b1111);
        set_rd(4'd2, 4'd5);
        tick();
        clr = 1'b1;
        wr(4'd2, 32'hDEADBEEF, 4'b1111);
        exp_busy(0, 1'b0, "clr_pre");
        exp_at(K_CMB_P0, 0, 32'h12345678, "clr_cmb_pre");
        exp_at(K_REG_P0, 1, 32'h0, "clr_reg_zero_p0");
        exp_at(K_REG_P1, 1, 32'h0, "clr_reg_zero_p1");
        for (int j = 1; j <= 16; j++) begin
            exp_busy(j, 1'b1, "clr_sweep");
            exp_at(K_CMB_P0, j, 32'h0, "clr_cmb_busy");
        end
        exp_busy(17, 1'b0, "clr_done");
        for (int j = 1; j <= 17; j++) begin
            tick();
            clr    = 1'b0;
            w_data = 32'hFFFFFFFF;
            wr_en  = (j <= 16);
        end
        exp_at(K_CMB_P0, 0, 32'h0, "clr_addr2_cmb");
        exp_at(K_CMB_P1, 0, 32'h0, "clr_addr5_cmb");
        exp_at(K_REG_P0, 0, 32'h0, "clr_addr2_reg_last");
        exp_at(K_REG_P0, 1, 32'h0, "clr_addr2_reg");
        exp_at(K_REG_P1, 1, 32'h0, "clr_addr5_reg");
        tick();

        // Reset at cnt=7 restarts the sweep; clr during busy is ignored.
        clr = 1'b1;
        set_rd(4'd7, 4'd3);
        for (int j = 1; j <= 24; j++) exp_busy(j, 1'b1, "rmid_sweep");
        exp_busy(25, 1'b0, "rmid_done");
        for (int m = 1; m <= 25; m++) begin
            tick();
            clr   = (m == 12 || m == 24);
            rst_n = (m != 8);
        end
        clr = 1'b0;
        wr(4'd7, 32'hCAFEF00D, 4'b1111);
        exp_at(K_CMB_P0, 0, 32'h0, "first_wr_cmb_old");
        exp_at(K_CMB_P1, 0, 32'h0, "rmid_addr3_cmb");
        exp_at(K_REG_P0, 1, 32'hCAFEF00D, "first_wr_reg");
        tick();
        wr_en = 1'b0;
        exp_at(K_CMB_P0, 0, 32'hCAFEF00D, "first_wr_cmb");
        repeat (3) tick();

        if (sb.size() != 0) begin
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
            n_miss += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with per-byte write enables, optional registered reads with write-first bypass, and a hardware clear sweep that zeroes every entry after reset or on request. It is the general-purpose storage block for datapaths needing several simultaneous operand reads and a known power-up state. It replaces the single-read, uninitialised register file wherever either property is required.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_W
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_RD, 2, number of independent read ports (1..8)
- REG_RD, 1, 1 = registered reads (1-cycle latency, write-first bypass); 0 = combinational reads
- BYTE_W, 8, bits per write-enable lane; LANES = DATA_WIDTH/BYTE_W
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low; one clock, no other clock domains
- clr  in  1  request a clear sweep (sampled only when busy=0)
- wr_en  in  1  write strobe
- w_addr  in  ADDR_WIDTH  write address
- w_data  in  DATA_WIDTH  write data
- w_be  in  LANES  per-lane write enable; lane i covers bits [i*BYTE_W +: BYTE_W]
- r_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- r_data  out  NUM_RD*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  clear sweep in progress; writes dropped, reads return 0

## Operation
- FSM states: CLEAR, IDLE.
- rst_n=0 at an edge: state<=CLEAR, sweep counter<=0, busy<=1, registered r_data<=0. Array contents not reset directly; the sweep zeroes them.
- CLEAR: each edge writes 0 to entry[cnt], cnt<=cnt+1. After the edge that writes entry DEPTH-1: state<=IDLE, busy<=0, cnt<=0 (wraps, no overflow).
- IDLE: clr=1 at an edge -> state<=CLEAR, cnt<=0, busy<=1. clr while busy=1 is ignored (no restart).
- Write (IDLE only): wr_en=1 updates lanes with w_be[i]=1; lanes with w_be[i]=0 keep old value. wr_en=1 with w_be=0 is a no-op. wr_en while busy=1 is dropped silently. clr and wr_en in the same IDLE cycle: clr wins, write dropped.
- Read, REG_RD=1: r_data[k] <= entry[r_addr[k]] each edge; if wr_en accepted and w_addr==r_addr[k], enabled lanes take w_data (write-first), others old value. While busy (or next state CLEAR), r_data <= 0.
- Read, REG_RD=0: r_data[k] = entry[r_addr[k]] combinationally, returns pre-write value in the write cycle; forced to 0 while busy=1.
- All read ports are independent; any number may address the same entry.

## Timing
- busy is 1 from the first edge with rst_n=0 through exactly DEPTH edges after rst_n returns high; first accepted write is on the edge after busy falls.
- clr sweep: busy rises the edge after clr is sampled, stays high DEPTH cycles.
- rst_n asserted mid-sweep: sweep restarts at cnt=0 on release; full DEPTH cycles again.
- Write latency: data visible to REG_RD=0 reads the cycle after the write edge; to REG_RD=1 reads at the same edge (bypass).
- REG_RD=1 read latency 1 cycle; REG_RD=0 latency 0.

## Structure
- Package reg_file_pkg: state enum typedef {CLEAR, IDLE}; function lanes(DATA_WIDTH, BYTE_W); constant for maximum NUM_RD.
- Sub-module reg_file_clear_ctrl: FSM plus ADDR_WIDTH-bit sweep counter; outputs busy, clear-write strobe, clear address. Top muxes sweep vs. user write into the array and generates NUM_RD read ports with a generate loop.
- Elaboration check: DATA_WIDTH % BYTE_W == 0, 1 <= NUM_RD <= 8.

## Test plan
- Reset sweep, DEPTH=16: hold rst_n=0 3 cycles, release -> busy high exactly 16 cycles after release; then all 16 entries read 0x00 on both ports.
- Byte enables, DATA_WIDTH=32, BYTE_W=8: write 0xAABBCCDD to addr 5 with w_be=4'b1111, then 0x11223344 with w_be=4'b0101 -> addr 5 reads 0xAA22CC44.
- Bypass, REG_RD=1: write 0x5A to addr 3 while port0 r_addr=3, port1 r_addr=4 -> next cycle port0=0x5A, port1 old value; REG_RD=0 same stimulus -> port0 shows old value in write cycle, 0x5A after.
- clr in IDLE with concurrent wr_en to addr 2 -> write dropped, busy high 16 cycles, addr 2 reads 0; wr_en during busy also dropped.
- Reset mid-sweep: assert rst_n=0 at cnt=7 for 1 cycle -> busy stays high 16 further cycles after release; clr pulses during busy ignored (busy length unchanged).
